// File: rtl/idct_transpose.sv
// Ping-pong 8x8 transpose buffer: rows written from the row IDCT, columns read by the column IDCT.
// One bank fills while the other drains; outputs come only from registered state.
module idct_transpose #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] c0,
    output logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c2,
    output logic [DATA_W-1:0] c3,
    output logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] c5,
    output logic [DATA_W-1:0] c6,
    output logic [DATA_W-1:0] c7,
    output logic [2:0]        col_idx,
    output logic              blk_last
);

    logic [DATA_W-1:0] mem [2][8][8];
    logic [DATA_W-1:0] row [8];
    logic [1:0]        full;
    logic              wbank;
    logic              rbank;
    logic [2:0]        wrow;
    logic [2:0]        rcol;
    logic              wr_acc;
    logic              rd_acc;

    assign row[0] = in0;
    assign row[1] = in1;
    assign row[2] = in2;
    assign row[3] = in3;
    assign row[4] = in4;
    assign row[5] = in5;
    assign row[6] = in6;
    assign row[7] = in7;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign wr_acc    = in_valid && in_ready;
    assign rd_acc    = out_valid && out_ready;

    // Write bank is never full and read bank always is, so both sides may update in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wrow  <= '0;
            rcol  <= '0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    for (int k = 0; k < 8; k++)
                        mem[b][r][k] <= '0;
        end else begin
            if (wr_acc) begin
                for (int k = 0; k < 8; k++)
                    mem[wbank][wrow][k] <= row[k];
                wrow <= wrow + 3'd1;
                if (wrow == 3'd7) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end
            if (rd_acc) begin
                rcol <= rcol + 3'd1;
                if (rcol == 3'd7) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end
            end
        end
    end

    assign c0       = mem[rbank][0][rcol];
    assign c1       = mem[rbank][1][rcol];
    assign c2       = mem[rbank][2][rcol];
    assign c3       = mem[rbank][3][rcol];
    assign c4       = mem[rbank][4][rcol];
    assign c5       = mem[rbank][5][rcol];
    assign c6       = mem[rbank][6][rcol];
    assign c7       = mem[rbank][7][rcol];
    assign col_idx  = rcol;
    assign blk_last = out_valid && (rcol == 3'd7);

endmodule

// File: tb/tb_idct_transpose.sv
// Bench for idct_transpose: directed scenarios plus random traffic against a block-queue model.
module tb_idct_transpose;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        blk_last;
    logic [2:0]  col_idx;
    logic [31:0] din [8];
    logic [31:0] cv  [8];

    int errors = 0;
    int checks = 0;

    // Model: completed blocks queued as 64 words each (row*8+col), head is being read.
    logic [31:0] done_q [$];
    logic [31:0] cur [64];
    int          wrow;
    int          rcol;
    bit          last_wa;
    bit          last_ra;

    always #5 clk = ~clk;

    idct_transpose #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .c0(cv[0]), .c1(cv[1]), .c2(cv[2]), .c3(cv[3]),
        .c4(cv[4]), .c5(cv[5]), .c6(cv[6]), .c7(cv[7]),
        .col_idx(col_idx), .blk_last(blk_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        done_q.delete();
        wrow = 0;
        rcol = 0;
    endtask

    task automatic set_pat(input int b, input int r);
        for (int k = 0; k < 8; k++) din[k] = 32'(100 * b + 10 * r + k);
    endtask

    task automatic set_rand();
        for (int k = 0; k < 8; k++) din[k] = $urandom;
    endtask

    // Check outputs for this cycle, take the edge, advance the model, end at edge+1.
    task automatic cycle();
        bit er, ev, wa, ra;
        er = done_q.size() < 128;
        ev = done_q.size() >= 64;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("col_idx", 32'(col_idx), 32'(rcol));
        chk("blk_last", 32'(blk_last), 32'(ev && rcol == 7));
        if (ev)
            for (int k = 0; k < 8; k++) chk("col_data", cv[k], done_q[k * 8 + rcol]);
        wa = in_valid && er;
        ra = out_ready && ev;
        @(posedge clk);
        if (ra) begin
            rcol++;
            if (rcol == 8) begin
                rcol = 0;
                for (int i = 0; i < 64; i++) void'(done_q.pop_front());
            end
        end
        if (wa) begin
            for (int k = 0; k < 8; k++) cur[wrow * 8 + k] = din[k];
            wrow++;
            if (wrow == 8) begin
                wrow = 0;
                for (int i = 0; i < 64; i++) done_q.push_back(cur[i]);
            end
        end
        last_wa = wa;
        last_ra = ra;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_col_idx"}, 32'(col_idx), 32'd0);
        chk({tag, "_blk_last"}, 32'(blk_last), 32'd0);
        for (int k = 0; k < 8; k++) chk({tag, "_c"}, cv[k], 32'd0);
    endtask

    initial begin
        int  acc;
        bit  pend;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = '0;
        model_reset();
        last_wa = 0;
        last_ra = 0;
        #2;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single block transpose
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_pat(0, r);
            cycle();
        end
        in_valid = 1'b0;
        chk("single_latency", 32'(out_valid), 32'd1);
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (c == 0) chk("single_col0", cv[r], 32'(10 * r));
                if (c == 3) chk("single_col3", cv[r], 32'(10 * r + 3));
            end
            chk("single_last", 32'(blk_last), 32'(c == 7));
            cycle();
        end
        chk("single_done", 32'(out_valid), 32'd0);

        // Signed pass-through
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_rand();
            if (r == 0) begin
                din[0] = 32'hFFFF_FFFF;
                din[7] = 32'h8000_0000;
            end
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) chk("signed_c0_col0", cv[0], 32'hFFFF_FFFF);
            if (c == 7) chk("signed_c0_col7", cv[0], 32'h8000_0000);
            cycle();
        end

        // Ping-pong streaming, 4 blocks
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i < 32) set_pat(i / 8, i % 8);
            else in_valid = 1'b0;
            if (i < 32) chk("stream_ready", 32'(in_ready), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'(i >= 8));
            cycle();
        end
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && acc < 16; i++) begin
            set_pat(acc / 8, acc % 8);
            cycle();
            if (last_wa) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd16);
        set_pat(2, 0);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        cycle();
        cycle();
        chk("bp_not_stored", 32'(last_wa), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 1'b0;
        chk("bp_release", 32'(in_ready), 32'd1);
        cycle();
        chk("bp_accept", 32'(last_wa), 32'd1);
        for (int r = 1; r < 8; r++) begin
            set_pat(2, r);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) chk("bp_blk2_r0", cv[0], 32'd200);
            cycle();
        end

        // Stall stability
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int r = 0; r < 8; r++) begin
            set_pat(5, r);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("stall_col", 32'(col_idx), 32'd4);
            chk("stall_c0", cv[0], 32'd504);
            chk("stall_c7", cv[7], 32'd574);
        end
        out_ready = 1'b1;
        cycle();
        chk("stall_resume", 32'(col_idx), 32'd5);
        for (int c = 0; c < 3; c++) cycle();

        // Random traffic with one asynchronous reset mid-run
        pend = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                #3;
                reset = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                model_reset();
                @(posedge clk);
                #1;
                check_reset_outputs("rst_held");
                reset = 1'b1;
                pend  = 0;
            end
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                set_rand();
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            pend = in_valid && !last_wa;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
